// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority-voted mid-bit
// sampling, feeding a show-ahead RX FIFO that stores {frame_err, parity_err}
// alongside each word.
// Optional break detection is compiled in with `define UART_RX_BREAK_DET_EN.
module uart_rx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   baud_div,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop_bits,
   input  logic                          uart_rx,
   input  logic                          rd_en,
   input  logic                          overrun_clr,
   output logic                          rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic [1:0]                    rd_status,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          break_det
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_WIDTH);
   localparam int unsigned EW = DATA_WIDTH + 2;

   localparam logic [SW-1:0] SC_A     = SW'(OVERSAMPLE/2 - 1);
   localparam logic [SW-1:0] SC_B     = SW'(OVERSAMPLE/2);
   localparam logic [SW-1:0] SC_DEC   = SW'(OVERSAMPLE/2 + 1);
   localparam logic [SW-1:0] SC_END   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY   = 3'd3,
      STOP1    = 3'd4,
      STOP2    = 3'd5
`ifdef UART_RX_BREAK_DET_EN
      ,BRK_WAIT = 3'd6
`endif
   } state_t;

   state_t                state, state_n;
   logic                  rx_meta, rxs, rxs_d, fall;
   logic [15:0]           tcnt, div_m1;
   logic                  tick;
   logic [SW-1:0]         sc;
   logic                  s_a, s_b, vote;
   logic                  at_a, at_b, at_dec, at_end;
   logic [DATA_WIDTH-1:0] shift;
   logic [BW-1:0]         bidx;
   logic                  perr, ferr, ferr_final;
   logic                  par_en, final_c, push_c;
   logic [EW-1:0]         push_word;
`ifdef UART_RX_BREAK_DET_EN
   logic                  par_bit, brk_q, brk_now, brk_final, brk_c;
`endif

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic                  do_pop, do_push, full, ovr_set;
   logic [CW-1:0]         count_n;
   logic [EW-1:0]         head_n;

   // Two-stage synchroniser plus edge register; all idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
      end
   end

   assign fall   = rxs_d & ~rxs;
   assign div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
   assign tick   = (tcnt >= div_m1);

   // Free-running sample-tick divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt <= 16'd0;
      else        tcnt <= tick ? 16'd0 : tcnt + 16'd1;
   end

   assign at_a       = (sc == SC_A);
   assign at_b       = (sc == SC_B);
   assign at_dec     = (sc == SC_DEC);
   assign at_end     = (sc == SC_END);
   assign vote       = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
   assign par_en     = (parity_mode == 2'd1) || (parity_mode == 2'd2);
   assign final_c    = tick && at_dec &&
                       (((state == STOP1) && !stop_bits) || (state == STOP2));
   assign ferr_final = (state == STOP2) ? (ferr | ~vote) : ~vote;
   assign push_word  = {ferr_final, perr, shift};
`ifdef UART_RX_BREAK_DET_EN
   assign brk_now    = (shift == '0) && !(par_en && par_bit) && !vote;
   assign brk_final  = (state == STOP2) ? brk_q : brk_now;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // FSM next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (fall) state_n = START;
         START:  if (tick) begin
                    if (at_dec && vote) state_n = IDLE;
                    else if (at_end)    state_n = DATA;
                 end
         DATA:   if (tick && at_end && (bidx == BIT_LAST))
                    state_n = par_en ? PARITY : STOP1;
         PARITY: if (tick && at_end) state_n = STOP1;
         STOP1,
         STOP2:  begin
                    if (final_c) begin
`ifdef UART_RX_BREAK_DET_EN
                       state_n = brk_final ? BRK_WAIT : IDLE;
`else
                       state_n = IDLE;
`endif
                    end else if ((state == STOP1) && tick && at_end && stop_bits) begin
                       state_n = STOP2;
                    end
                 end
`ifdef UART_RX_BREAK_DET_EN
         BRK_WAIT: if (tick && rxs && at_end) state_n = IDLE;
`endif
         default: state_n = IDLE;
      endcase
   end

   // FSM outputs: push or break strobe at the final stop-bit decision.
   always_comb begin
      push_c = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_c  = 1'b0;
      if (final_c) begin
         brk_c  = brk_final;
         push_c = !brk_final;
      end
`else
      push_c = final_c;
`endif
   end

   // Bit-timing counter, vote samples and frame assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc    <= '0;
         s_a   <= 1'b1;
         s_b   <= 1'b1;
         shift <= '0;
         bidx  <= '0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         par_bit <= 1'b0;
         brk_q   <= 1'b0;
`endif
      end else if (state == IDLE) begin
         if (fall) begin
            sc   <= '0;
            bidx <= '0;
            perr <= 1'b0;
            ferr <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q <= 1'b0;
`endif
         end
      end else if (tick) begin
         sc <= at_end ? '0 : sc + SW'(1);
         if (at_a) s_a <= rxs;
         if (at_b) s_b <= rxs;
         if (at_dec) begin
            case (state)
               DATA:   shift <= {vote, shift[DATA_WIDTH-1:1]};
               PARITY: begin
`ifdef UART_RX_BREAK_DET_EN
                  par_bit <= vote;
`endif
                  perr <= (parity_mode == 2'd1) ? ((^shift) != vote)
                                                : ((~(^shift)) != vote);
               end
               STOP1:  begin
                  ferr <= ~vote;
`ifdef UART_RX_BREAK_DET_EN
                  brk_q <= brk_now;
`endif
               end
               default: ;
            endcase
         end
         if (at_end && (state == DATA)) bidx <= bidx + BW'(1);
`ifdef UART_RX_BREAK_DET_EN
         // BRK_WAIT counts consecutive high ticks; any low restarts it.
         if (final_c && brk_final)            sc <= '0;
         if ((state == BRK_WAIT) && !rxs)     sc <= '0;
`endif
      end
   end

   assign do_pop  = rd_en && (fifo_count != '0);
   assign full    = (fifo_count == CNT_FULL);
   assign do_push = push_c && (!full || do_pop);
   assign ovr_set = push_c && full && !do_pop;
   assign count_n = fifo_count + CW'(do_push) - CW'(do_pop);

   // Next show-ahead head word, bypassing the array when it is being written.
   always_comb begin
      head_n = {rd_status, rd_data};
      if (do_pop) begin
         if (fifo_count == CW'(1)) begin
            if (do_push) head_n = push_word;
         end else begin
            head_n = mem[rd_ptr + AW'(1)];
         end
      end else if (do_push && (fifo_count == '0)) begin
         head_n = push_word;
      end
   end

   // FIFO storage array.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

   // FIFO pointers, occupancy, registered head and sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         rd_status  <= 2'b00;
         overrun    <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= count_n;
         rd_valid   <= (count_n != '0);
         {rd_status, rd_data} <= head_n;
         if (ovr_set)          overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         break_det <= brk_c;
`else
         break_det <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: table-driven frames checked through a scoreboard,
// plus sequences for glitch, noise, 6-bit build, overrun, break and reset.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        stop_bits;
   logic        rx, rx6;
   logic        rd_en, rd_en6, overrun_clr;

   logic        rd_valid, overrun, break_det;
   logic [7:0]  rd_data;
   logic [1:0]  rd_status;
   logic [2:0]  fifo_count;

   logic        v6, ovr6, brk6;
   logic [5:0]  d6;
   logic [1:0]  st6;
   logic [2:0]  cnt6;

   int n_checks = 0;
   int n_pass   = 0;
   int brk_cnt  = 0;

   typedef struct {
      logic [7:0] d;
      logic [1:0] st;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [7:0] data;
      logic [1:0] pmode;
      logic       sb;
      logic       par;
      logic       s1;
      logic       s2;
      logic [7:0] exp_d;
      logic [1:0] exp_st;
   } vec_t;
   vec_t vecs [9];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .OVERSAMPLE(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .stop_bits(stop_bits), .uart_rx(rx), .rd_en(rd_en), .overrun_clr(overrun_clr),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_status(rd_status),
      .fifo_count(fifo_count), .overrun(overrun), .break_det(break_det)
   );

   uart_rx_fifo #(.DATA_WIDTH(6), .FIFO_DEPTH(4), .OVERSAMPLE(16)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .stop_bits(stop_bits), .uart_rx(rx6), .rd_en(rd_en6), .overrun_clr(overrun_clr),
      .rd_valid(v6), .rd_data(d6), .rd_status(st6),
      .fifo_count(cnt6), .overrun(ovr6), .break_det(brk6)
   );

   always @(negedge clk) if (break_det) brk_cnt <= brk_cnt + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic drive_line(input bit sel, input logic v);
      if (sel) rx6 = v;
      else     rx  = v;
   endtask

   // One bit period (16 clk); optionally a 1-clk inverted spike mid-bit.
   task automatic send_bit(input bit sel, input logic v, input bit noise);
      drive_line(sel, v);
      if (noise) begin
         repeat (8) @(negedge clk);
         drive_line(sel, ~v);
         @(negedge clk);
         drive_line(sel, v);
         repeat (7) @(negedge clk);
      end else begin
         repeat (16) @(negedge clk);
      end
   endtask

   task automatic send_frame(input bit sel, input int nbits, input logic [8:0] data,
                             input bit par_on, input logic par, input logic s1,
                             input bit two, input logic s2, input int noise_bit);
      send_bit(sel, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) send_bit(sel, data[i], i == noise_bit);
      if (par_on) send_bit(sel, par, 1'b0);
      send_bit(sel, s1, 1'b0);
      if (two) send_bit(sel, s2, 1'b0);
      drive_line(sel, 1'b1);
   endtask

   task automatic idle_bits(input int n);
      repeat (16 * n) @(negedge clk);
   endtask

   // Wait (bounded) for a head word, compare against the scoreboard, pop it.
   task automatic drain_one(input string name);
      int   w = 0;
      exp_t e;
      while (!rd_valid && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk({name, "_valid"}, int'(rd_valid), 1);
      if (rd_valid) begin
         chk({name, "_sb_nonempty"}, int'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({name, "_data"}, int'(rd_data), int'(e.d));
            chk({name, "_status"}, int'(rd_status), int'(e.st));
         end
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
   endtask

   initial begin
      int b0;
      rst_n       = 1'b0;
      baud_div    = 16'd1;
      parity_mode = 2'd0;
      stop_bits   = 1'b0;
      rx          = 1'b1;
      rx6         = 1'b1;
      rd_en       = 1'b0;
      rd_en6      = 1'b0;
      overrun_clr = 1'b0;

      vecs[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 2'b00};
      vecs[1] = '{8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 2'b01};
      vecs[2] = '{8'h07, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 2'b00};
      vecs[3] = '{8'h3C, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 2'b10};
      vecs[4] = '{8'hFF, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 2'b00};
      vecs[5] = '{8'h00, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 2'b00};
      vecs[6] = '{8'h81, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 2'b00};
      vecs[7] = '{8'h5A, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 2'b00};
      vecs[8] = '{8'h12, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 2'b10};

      repeat (4) @(negedge clk);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_rd_status", int'(rd_status), 0);
      chk("rst_fifo_count", int'(fifo_count), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_break_det", int'(break_det), 0);
      rst_n = 1'b1;
      idle_bits(2);

      // Table-driven single frames.
      for (int i = 0; i < 9; i++) begin
         parity_mode = vecs[i].pmode;
         stop_bits   = vecs[i].sb;
         idle_bits(1);
         sb_q.push_back('{vecs[i].exp_d, vecs[i].exp_st});
         send_frame(1'b0, 8, 9'(vecs[i].data),
                    (vecs[i].pmode == 2'd1) || (vecs[i].pmode == 2'd2),
                    vecs[i].par, vecs[i].s1, vecs[i].sb, vecs[i].s2, -1);
         repeat (4) @(negedge clk);
         chk($sformatf("vec%0d_count", i), int'(fifo_count), 1);
         drain_one($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_empty", i), int'(rd_valid), 0);
      end
      parity_mode = 2'd0;
      stop_bits   = 1'b0;
      idle_bits(1);

      // Short low glitch is a false start; the next real frame still lands.
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      idle_bits(3);
      chk("glitch_no_push", int'(rd_valid), 0);
      chk("glitch_count", int'(fifo_count), 0);
      sb_q.push_back('{8'hA5, 2'b00});
      send_frame(1'b0, 8, 9'h0A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      drain_one("after_glitch");

      // Single-clk spike inside a data bit is outvoted.
      idle_bits(1);
      sb_q.push_back('{8'h96, 2'b00});
      send_frame(1'b0, 8, 9'h096, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4);
      drain_one("noise_b4");
      sb_q.push_back('{8'h3C, 2'b00});
      send_frame(1'b0, 8, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      drain_one("noise_b0");

      // 6-bit instance.
      idle_bits(1);
      send_frame(1'b1, 6, 9'h02A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
      chk("w6_valid", int'(v6), 1);
      chk("w6_data", int'(d6), 'h2A);
      chk("w6_status", int'(st6), 0);
      chk("w6_count", int'(cnt6), 1);

      // Five back-to-back frames into a 4-deep FIFO.
      idle_bits(1);
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) sb_q.push_back('{8'(i), 2'b00});
         send_frame(1'b0, 8, 9'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      end
      idle_bits(1);
      chk("ovr_count", int'(fifo_count), 4);
      chk("ovr_set", int'(overrun), 1);
      for (int i = 1; i <= 4; i++) drain_one($sformatf("ovr_rd%0d", i));
      @(negedge clk);
      chk("ovr_drained", int'(rd_valid), 0);
      chk("ovr_sticky", int'(overrun), 1);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      @(negedge clk);
      chk("ovr_clr", int'(overrun), 0);

      // Line held low for 20 bit periods.
      idle_bits(1);
      b0 = brk_cnt;
      rx = 1'b0;
      idle_bits(20);
      rx = 1'b1;
      idle_bits(2);
`ifdef UART_RX_BREAK_DET_EN
      chk("brk_pulses", brk_cnt - b0, 1);
      chk("brk_no_push", int'(fifo_count), 0);
`else
      chk("brk_pulses", brk_cnt - b0, 0);
      chk("brk_push_count", int'(fifo_count), 1);
      sb_q.push_back('{8'h00, 2'b10});
      drain_one("brk_word");
`endif
      sb_q.push_back('{8'h55, 2'b00});
      send_frame(1'b0, 8, 9'h055, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      drain_one("after_brk");

      // Reset mid-frame empties the FIFO and drops the partial frame.
      idle_bits(1);
      send_frame(1'b0, 8, 9'h033, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
      chk("mid_rst_pre_count", int'(fifo_count), 1);
      rx = 1'b0;
      idle_bits(3);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_bits(12);
      chk("mid_rst_count", int'(fifo_count), 0);
      chk("mid_rst_valid", int'(rd_valid), 0);
      chk("mid_rst_data", int'(rd_data), 0);
      chk("sb_empty", int'(sb_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised oversampling UART receiver with a buffered read side, and the next generation of the current single-word receiver. It recovers 5–9-bit frames from `uart_rx` using majority-voted mid-bit sampling. Received words go into a show-ahead FIFO along with per-word error status. It sits between the serial pin and a register or bus front-end, which drains it at its own pace.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, default 16: entries in the RX FIFO; power of two, ≥2.
- `OVERSAMPLE`, default 16: sample ticks per bit; legal values 8 or 16.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `baud_div` input, 16 bits: clk cycles per sample tick; 0 is treated as 1.
- `parity_mode` input, 2 bits: 0 = none, 1 = even, 2 = odd, 3 = none.
- `stop_bits` input, 1 bit: 0 = one stop bit, 1 = two stop bits.
- `uart_rx` input, 1 bit: serial line, asynchronous, idle high.
- `rd_en` input, 1 bit: pop the FIFO head; ignored when the FIFO is empty.
- `overrun_clr` input, 1 bit: clears `overrun`.
- `rd_valid` output, 1 bit: FIFO not empty.
- `rd_data` output, `DATA_WIDTH` bits: head data, show-ahead.
- `rd_status` output, 2 bits: head status, {frame_err, parity_err}.
- `fifo_count` output, `$clog2(FIFO_DEPTH)+1` bits: number of occupied entries.
- `overrun` output, 1 bit: sticky; set when a frame is dropped because the FIFO is full.
- `break_det` output, 1 bit: one-cycle pulse on a detected break.

## Operation
- `uart_rx` passes through a 2-FF synchroniser that resets to 1. All logic uses the synchronised value `rxs`.
- Tick generator:
  - Counter 0..max(`baud_div`,1)−1.
  - One-cycle `tick` pulse at terminal count.
  - Free-running; not restarted on start detection.
  - Bit period = `OVERSAMPLE` ticks.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT (BRK_WAIT exists only with the macro defined).
- IDLE: a falling edge of `rxs` (previous 1, now 0) clears the sample counter `sc` and moves to START. A line held low does not retrigger.
- Sampling:
  - `sc` counts ticks 0..OVERSAMPLE−1 within each bit.
  - The bit value is the majority of `rxs` at `sc` = OS/2−1, OS/2 and OS/2+1.
  - Bit decision happens at `sc` = OS/2+1.
  - Advance to the next bit happens at `sc` = OS−1.
- START: if the voted value is 1, it is a false start; return to IDLE with nothing pushed.
- DATA: `DATA_WIDTH` bits, LSB first. Go to PARITY if `parity_mode` is 1 or 2, otherwise to STOP1.
- PARITY check:
  - Even: `parity_err` = (^data) ≠ bit.
  - Odd: `parity_err` = ~(^data) ≠ bit.
- STOP1: `frame_err` is set if the voted value is 0.
  - If `stop_bits` = 1, go to STOP2. STOP2 is checked the same way and its error is ORed into `frame_err`.
  - At the decision point of the final stop bit, the frame is pushed and the FSM returns to IDLE. This half-bit early return allows back-to-back frames.
- FIFO rules:
  - A push when full drops the frame and sets `overrun`.
  - A push and a pop in the same cycle while full both succeed; `fifo_count` is unchanged and `overrun` is not set.
  - A pop when empty has no effect.
  - If `overrun_clr` and a new overrun occur in the same cycle, the set wins.
- `parity_mode` and `stop_bits` are sampled live. Software changes them only while IDLE and the line is idle.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_data`=0, `rd_status`=0, `fifo_count`=0, `overrun`=0, `break_det`=0.
  - FSM in IDLE, tick counter 0, synchroniser 1.
- Asserting reset mid-frame discards the partial frame and empties the FIFO.
- Pin edge to FSM leaving IDLE: 3 clk (2 synchroniser stages plus 1 edge register).
- Push to `rd_valid`/`fifo_count` update: 1 clk. `rd_data`/`rd_status` are valid in the same cycle `rd_valid` rises.
- Pop: the next entry appears on the cycle after `rd_en`.
- `break_det` pulses in the cycle the frame would otherwise be pushed.

## Configuration
- Macro: `UART_RX_BREAK_DET_EN`.
- Defined:
  - A frame with all data bits 0, parity bit 0 (if enabled) and first stop bit 0 is a break.
  - It is not pushed. `break_det` pulses for 1 clk.
  - The FSM enters BRK_WAIT and returns to IDLE only after `rxs` has been 1 for one full bit period (OVERSAMPLE ticks).
- Undefined:
  - `break_det` is tied to 0 and BRK_WAIT is absent.
  - The same frame is pushed as data 0 with `frame_err`=1. Normal falling-edge start detection handles the rest.

## Test plan
- Setup for all scenarios: OVERSAMPLE=16, `baud_div`=1 (16 clk per bit), 8N1.
- Send 0xA5 → after one frame `rd_valid`=1, `rd_data`=0xA5, `rd_status`=00, `fifo_count`=1. `rd_en` for one cycle → `rd_valid`=0.
- Even parity, send 0x07 with parity bit forced to 0 → `rd_data`=0x07, `rd_status`=01. Odd parity with a correct parity bit → `rd_status`=00.
- 8N2, second stop bit driven 0 → `rd_status`=10. 6-bit build, send 0x2A → `rd_data`=0x2A.
- Low glitch of 5 clk on an idle line → no push, FSM back to IDLE. Single-tick noise inside a data bit → majority vote recovers the correct byte.
- FIFO_DEPTH=4, 5 back-to-back frames 0x01..0x05 with no reads → `fifo_count`=4, `overrun`=1, reads return 0x01..0x04. `overrun_clr` → `overrun`=0.
- Line held low for 20 bit periods with the macro defined → one `break_det` pulse, no push. Without the macro → one entry with data 0x00 and `rd_status`=10. In both builds, 0x55 sent after the line returns high is received correctly.
